// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART RX frame parser: SOF default, error codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_frame_pkg;

  // Default start-of-frame marker
  localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;

  // Drop causes reported on err_code
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // Parser states
  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // 8-bit saturating increment for the drop counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_byte_fetch.sv
// Pops the RX FIFO one byte at a time and presents each byte with a one-cycle valid.
// Latency: byte_valid follows the rd_uart pulse by one cycle (R_data passed straight through).
// Backpressure: no pop while fetch_en is low, the FIFO is empty, or a pop is still in flight.
module uart_byte_fetch
  import uart_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  rx_empty,
  input  logic [DATA_WIDTH-1:0] R_data,
  output logic                  rd_uart,
  output logic                  byte_valid,
  output logic [DATA_WIDTH-1:0] rx_byte
);

  logic pend_q;
  logic pend_d;

  // Issue a pop only when nothing is outstanding; gated by reset so the strobe is quiet in reset
  always_comb begin
    rd_uart = fetch_en && !pend_q && !rx_empty && !reset;
    pend_d  = rd_uart;
  end

  // Track the single outstanding pop; reset drops a byte that is still in flight
  always_ff @(posedge UCLK) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign byte_valid = pend_q;
  assign rx_byte    = R_data;

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Delineates SOF/LEN/payload/CSUM frames from the RX FIFO and holds checked packets for the host.
// Latency: pkt_valid rises the cycle after the checksum byte is accepted; pkt_err one cycle after the fault.
// Backpressure: while a packet is held (DONE) no bytes are popped until pkt_ack.
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MAX_PAYLOAD    = 16,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = DATA_WIDTH'(SOF_BYTE_DEF),
  parameter int                    TIMEOUT_CYCLES = 50000,
  parameter int                    LEN_BITS       = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  rx_empty,
  input  logic [DATA_WIDTH-1:0] R_data,
  output logic                  rd_uart,
  output logic                  pkt_valid,
  output logic [LEN_BITS-1:0]   pkt_len,
  input  logic [LEN_BITS-1:0]   pkt_rd_addr,
  output logic [DATA_WIDTH-1:0] pkt_rd_data,
  input  logic                  pkt_ack,
  output logic                  pkt_err,
  output logic [1:0]            err_code,
  output logic [7:0]            err_cnt
);

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Byte stream from the FIFO
  logic                  fetch_en;
  logic                  byte_valid;
  logic [DATA_WIDTH-1:0] rx_byte;

  // Parser state
  state_e                state_q, state_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [LEN_BITS-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  pkt_valid_q, pkt_valid_d;
  logic [LEN_BITS-1:0]   pkt_len_q, pkt_len_d;
  logic                  pkt_err_q, pkt_err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  // Payload buffer write port
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] buf_q [MAX_PAYLOAD];

  // Drop decision for this cycle
  logic                  drop;
  logic [1:0]            drop_code;
  logic                  timer_live;

  // A held packet stops popping; anything already in flight lands and is ignored in DONE
  assign fetch_en = (state_q != ST_DONE);

  uart_byte_fetch #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fetch (
    .UCLK       (UCLK),
    .reset      (reset),
    .fetch_en   (fetch_en),
    .rx_empty   (rx_empty),
    .R_data     (R_data),
    .rd_uart    (rd_uart),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
  );

  // Next-state logic: frame walk, inter-byte timeout and drop bookkeeping
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    pkt_valid_d = pkt_valid_q;
    pkt_len_d   = pkt_len_q;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    err_cnt_d   = err_cnt_q;
    wr_en       = 1'b0;
    wr_addr     = idx_q[AW-1:0];
    drop        = 1'b0;
    drop_code   = ERR_NONE;

    // The timer only runs inside a frame and restarts on every byte
    timer_live = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    tmo_d      = timer_live ? tmo_q + 1'b1 : '0;
    if (byte_valid) begin
      tmo_d = '0;
    end

    case (state_q)
      ST_HUNT: begin
        if (byte_valid && rx_byte == SOF_BYTE) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (byte_valid) begin
          if (rx_byte == '0 || int'(rx_byte) > MAX_PAYLOAD) begin
            drop      = 1'b1;
            drop_code = ERR_LEN;
          end else begin
            len_d   = LEN_BITS'(rx_byte);
            sum_d   = rx_byte;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (byte_valid) begin
          wr_en = 1'b1;
          sum_d = sum_q + rx_byte;
          idx_d = idx_q + 1'b1;
          if (idx_d == len_q) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (byte_valid) begin
          if (rx_byte == sum_q) begin
            state_d     = ST_DONE;
            pkt_valid_d = 1'b1;
            pkt_len_d   = len_q;
          end else begin
            drop      = 1'b1;
            drop_code = ERR_CSUM;
          end
        end
      end
      ST_DONE: begin
        if (pkt_ack) begin
          state_d     = ST_HUNT;
          pkt_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // A byte arriving on the expiry cycle keeps the frame alive
    if (timer_live && !byte_valid && tmo_q == TMO_LAST) begin
      drop      = 1'b1;
      drop_code = ERR_TMO;
    end

    if (drop) begin
      state_d    = ST_HUNT;
      pkt_err_d  = 1'b1;
      err_code_d = drop_code;
      err_cnt_d  = sat_inc8(err_cnt_q);
    end
  end

  // FSM and registered outputs
  always_ff @(posedge UCLK) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      pkt_valid_q <= 1'b0;
      pkt_len_q   <= '0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_len_q   <= pkt_len_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Payload buffer; contents are only meaningful while pkt_valid is high
  always_ff @(posedge UCLK) begin
    if (wr_en) begin
      buf_q[wr_addr] <= rx_byte;
    end
  end

  assign pkt_rd_data = (int'(pkt_rd_addr) < MAX_PAYLOAD) ? buf_q[pkt_rd_addr[AW-1:0]] : '0;
  assign pkt_valid   = pkt_valid_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_err     = pkt_err_q;
  assign err_code    = err_code_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: FIFO model feeds frames, a scoreboard checks packets and drops.
// Latency: n/a.
// Backpressure: host side holds each packet a few cycles before acking.
module tb_uart_rx_frame_parser;

  localparam int         TMO = 50000;
  localparam logic [7:0] SOF = 8'hA5;

  logic       UCLK = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] R_data = 8'h00;
  logic       rd_uart;
  logic       pkt_valid;
  logic [4:0] pkt_len;
  logic [4:0] pkt_rd_addr = 5'd0;
  logic [7:0] pkt_rd_data;
  logic       pkt_ack = 1'b0;
  logic       pkt_err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;

  uart_rx_frame_parser dut (
    .UCLK        (UCLK),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .R_data      (R_data),
    .rd_uart     (rd_uart),
    .pkt_valid   (pkt_valid),
    .pkt_len     (pkt_len),
    .pkt_rd_addr (pkt_rd_addr),
    .pkt_rd_data (pkt_rd_data),
    .pkt_ack     (pkt_ack),
    .pkt_err     (pkt_err),
    .err_code    (err_code),
    .err_cnt     (err_cnt)
  );

  always #50 UCLK = ~UCLK;

  typedef struct {
    bit           is_err;
    logic [1:0]   code;
    int           len;
    logic [127:0] data;
    bit           tmo;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_pop = 0;
  int         underflows = 0;
  int         cnt_model = 0;
  logic       pop_req = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: the pop strobe is sampled mid-cycle and serviced on the next edge
  always @(negedge UCLK) begin
    cyc = cyc + 1;
    pop_req = rd_uart;
    if (rd_uart) last_pop = cyc;
  end

  always @(posedge UCLK) begin
    if (pop_req) begin
      if (fifo_q.size() == 0) underflows <= underflows + 1;
      else R_data <= fifo_q.pop_front();
    end
    rx_empty <= (fifo_q.size() == 0);
  end

  task automatic push_b(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic exp_err(input logic [1:0] code, input bit tmo);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.len = 0; e.data = '0; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic exp_pkt(input int len, input logic [127:0] data);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.len = len; e.data = data; e.tmo = 1'b0;
    exp_q.push_back(e);
  endtask

  // Random payload; checksum is LEN plus every payload byte, modulo 256
  task automatic send_frame(input int len);
    logic [127:0] d;
    logic [7:0]   s;
    d = '0;
    s = 8'(len);
    for (int i = 0; i < len; i++) begin
      d[i*8 +: 8] = 8'($urandom_range(0, 255));
      s = s + d[i*8 +: 8];
    end
    exp_pkt(len, d);
    push_b(SOF);
    push_b(8'(len));
    for (int i = 0; i < len; i++) push_b(d[i*8 +: 8]);
    push_b(s);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      @(negedge UCLK);
      n++;
    end
    check_val("idle_budget", 32'(n < budget), 32'd1);
    repeat (12) @(negedge UCLK);
  endtask

  // Host side: compares each drop and each held packet against the scoreboard
  initial begin : consumer
    exp_t ev;
    forever begin
      @(negedge UCLK);
      if (reset) begin
        cnt_model = 0;
      end else if (pkt_err) begin
        if (exp_q.size() == 0) begin
          check_val("unexp_err", 32'(pkt_err), 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check_val("evt_kind_err", 32'(pkt_err), 32'(ev.is_err));
          if (ev.is_err) begin
            cnt_model = (cnt_model == 255) ? 255 : cnt_model + 1;
            check_val("err_code", 32'(err_code), 32'(ev.code));
            check_val("err_cnt", 32'(err_cnt), 32'(cnt_model));
            check_val("pkt_valid_on_err", 32'(pkt_valid), 32'd0);
            if (ev.tmo)
              check_val("tmo_window", 32'((cyc - last_pop) >= TMO && (cyc - last_pop) <= TMO + 4), 32'd1);
          end
        end
      end else if (pkt_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexp_pkt", 32'(pkt_valid), 32'd0);
        end else begin
          ev = exp_q.pop_front();
          check_val("evt_kind_pkt", 32'(pkt_err), 32'(ev.is_err));
          if (!ev.is_err) begin
            check_val("pkt_len", 32'(pkt_len), 32'(ev.len));
            for (int i = 0; i < ev.len; i++) begin
              pkt_rd_addr = 5'(i);
              #1;
              check_val("pkt_data", 32'(pkt_rd_data), 32'(ev.data[i*8 +: 8]));
            end
          end
        end
        // Hold the packet a few cycles; nothing may be popped meanwhile
        repeat (4) begin
          @(negedge UCLK);
          check_val("no_pop_done", 32'(rd_uart), 32'd0);
          check_val("valid_held", 32'(pkt_valid), 32'd1);
        end
        pkt_ack = 1'b1;
        @(negedge UCLK);
        pkt_ack = 1'b0;
        check_val("valid_fall", 32'(pkt_valid), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #(64'd100 * 64'd150000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rd_uart"}, 32'(rd_uart), 32'd0);
    check_val({tag, "_pkt_valid"}, 32'(pkt_valid), 32'd0);
    check_val({tag, "_pkt_err"}, 32'(pkt_err), 32'd0);
    check_val({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
    check_val({tag, "_err_code"}, 32'(err_code), 32'd0);
    check_val({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin : stim
    reset = 1'b1;
    repeat (3) @(negedge UCLK);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge UCLK);

    // Good frame followed by garbage and a one-byte frame, queued while the first is held
    exp_pkt(3, {104'd0, 8'h33, 8'h22, 8'h11});
    exp_pkt(1, {120'd0, 8'h7E});
    foreach (fifo_q[i]) ;
    push_b(8'hA5); push_b(8'h03); push_b(8'h11); push_b(8'h22); push_b(8'h33); push_b(8'h69);
    push_b(8'h00); push_b(8'hFF); push_b(8'hA5); push_b(8'h01); push_b(8'h7E); push_b(8'h7F);
    wait_idle(400);
    check_val("no_err_garbage", 32'(err_cnt), 32'd0);

    // Bad lengths: zero, then one above the maximum, then resync
    exp_err(2'd1, 1'b0);
    push_b(8'hA5); push_b(8'h00);
    wait_idle(200);
    exp_err(2'd1, 1'b0);
    exp_pkt(1, {120'd0, 8'h5A});
    push_b(8'hA5); push_b(8'h11); push_b(8'hA5); push_b(8'h01); push_b(8'h5A); push_b(8'h5B);
    wait_idle(300);
    check_val("badlen_cnt", 32'(err_cnt), 32'd2);
    check_val("badlen_code_held", 32'(err_code), 32'd1);

    // Checksum failure then an accepted frame
    exp_err(2'd2, 1'b0);
    exp_pkt(1, {120'd0, 8'h05});
    push_b(8'hA5); push_b(8'h02); push_b(8'h10); push_b(8'h20); push_b(8'h00);
    push_b(8'hA5); push_b(8'h01); push_b(8'h05); push_b(8'h06);
    wait_idle(300);
    check_val("csum_code_held", 32'(err_code), 32'd2);

    // Inter-byte timeout; the late bytes land in HUNT as garbage
    exp_err(2'd3, 1'b1);
    push_b(8'hA5); push_b(8'h02); push_b(8'h10);
    wait_idle(TMO + 1000);
    push_b(8'h20); push_b(8'h32);
    wait_idle(100);
    check_val("tmo_code", 32'(err_code), 32'd3);
    check_val("tmo_cnt", 32'(err_cnt), 32'd4);
    send_frame(2);
    wait_idle(300);

    // Reset in the middle of a payload, with a byte waiting in the FIFO
    push_b(8'hA5); push_b(8'h05); push_b(8'h01); push_b(8'h02);
    wait_idle(100);
    push_b(8'h00);
    reset = 1'b1;
    repeat (3) @(negedge UCLK);
    check_reset_outputs("midrst");
    reset = 1'b0;
    send_frame(16);
    send_frame(1);
    wait_idle(600);
    check_val("post_rst_cnt", 32'(err_cnt), 32'd0);

    // Drop counter saturation
    for (int k = 0; k < 260; k++) begin
      exp_err(2'd1, 1'b0);
      push_b(8'hA5); push_b(8'h00);
    end
    wait_idle(5000);
    check_val("err_cnt_sat", 32'(err_cnt), 32'd255);
    check_val("sat_code", 32'(err_code), 32'd1);
    check_val("fifo_underflow", 32'(underflows), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
